// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b over WIDTH cycles, LSB first, with a registered borrow.
// Optional build macro SERIAL_SUBTRACTOR_SAT_EN clamps an underflowing result to zero.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             d;
  logic             bout;

`ifdef SERIAL_SUBTRACTOR_SAT_EN
  function automatic logic [WIDTH-1:0] sat_diff(input logic [WIDTH-1:0] r, input logic brw);
    return brw ? '0 : r;
  endfunction
`endif

  // Full-subtractor cell applied to the current LSBs of the operand shifters
  always_comb begin
    d    = sa[0] ^ sb[0] ^ bin;
    bout = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      cnt    <= '0;
      bin    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            res   <= '0;
            cnt   <= '0;
            bin   <= 1'b0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res <= {d, res[WIDTH-1:1]};
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          bin <= bout;
          cnt <= cnt + 1'b1;
          // busy also rises here after a restart from DONE, so it never overlaps done
          busy <= (cnt != LAST);
          if (cnt == LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
`ifdef SERIAL_SUBTRACTOR_SAT_EN
          diff <= sat_diff(res, bin);
`else
          diff <= res;
`endif
          borrow <= bin;
          done   <= 1'b1;
          busy   <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            res   <= '0;
            cnt   <= '0;
            bin   <= 1'b0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, corner sequences, random ops.
module tb_serial_subtractor;

  localparam int W = 8;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int checks = 0;
  int failures = 0;
  int overlap = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .borrow(borrow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && busy && done) overlap++;
  end

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] ed;
    logic         eb;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic modulo 2^W, optional clamp on underflow
  function automatic logic [W:0] ref_sub(input int unsigned x, input int unsigned y);
    int unsigned m;
    logic        brw;
    m   = (x + (1 << W) - y) % (1 << W);
    brw = (x < y);
    if (SAT && brw) m = 0;
    return {brw, W'(m)};
  endfunction

  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        output logic [W-1:0] gd, output logic gb,
                        output int lat, output int bcnt);
    a = va;
    b = vb;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 0;
    bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      tick();
      lat++;
    end
    gd = diff;
    gb = borrow;
  endtask

  initial begin
    logic [W-1:0] gd;
    logic         gb;
    int           lat;
    int           bcnt;
    logic [W:0]   exp;
    int           dcnt;
    int           k;
    int           t[2];
    logic [W-1:0] dv[2];
    logic         bv[2];

    vecs[0] = '{8'd200, 8'd55,  8'h91, 1'b0};
    vecs[1] = '{8'd55,  8'd200, SAT ? 8'h00 : 8'h6F, 1'b1};
    vecs[2] = '{8'd0,   8'd1,   SAT ? 8'h00 : 8'hFF, 1'b1};
    vecs[3] = '{8'd0,   8'd0,   8'h00, 1'b0};
    vecs[4] = '{8'd255, 8'd255, 8'h00, 1'b0};
    vecs[5] = '{8'd255, 8'd0,   8'hFF, 1'b0};
    vecs[6] = '{8'd0,   8'd255, SAT ? 8'h00 : 8'h01, 1'b1};
    vecs[7] = '{8'd128, 8'd127, 8'h01, 1'b0};

    // Reset then idle
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("idle_%0d", i), {busy, done, diff, borrow}, '0);
      tick();
    end

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].va, vecs[i].vb, gd, gb, lat, bcnt);
      chk($sformatf("vec%0d_diff", i), gd, vecs[i].ed);
      chk($sformatf("vec%0d_borrow", i), gb, vecs[i].eb);
      chk($sformatf("vec%0d_latency", i), lat, W + 1);
      chk($sformatf("vec%0d_busycycles", i), bcnt, W);
      tick();
      chk($sformatf("vec%0d_donepulse", i), done, 1'b0);
      chk($sformatf("vec%0d_hold", i), {diff, borrow}, {vecs[i].ed, vecs[i].eb});
      repeat (i % 3) tick();
    end

    // Start ignored while busy
    a = 8'd10;
    b = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    a = 8'hFF;
    b = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 4;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    chk("ignore_latency", lat, W + 1);
    chk("ignore_diff", diff, 8'h07);
    chk("ignore_borrow", borrow, 1'b0);
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dcnt++;
    end
    chk("ignore_no_second_done", dcnt, 0);

    // Back-to-back with start held high
    a = 8'd9;
    b = 8'd4;
    start = 1'b1;
    tick();
    a = 8'd4;
    b = 8'd9;
    k = 0;
    for (int n = 0; n < 40 && k < 2; n++) begin
      if (done) begin
        t[k] = n;
        dv[k] = diff;
        bv[k] = borrow;
        k++;
        start = 1'b0;
      end
      if (k < 2) tick();
    end
    chk("b2b_count", k, 2);
    if (k == 2) begin
      chk("b2b_spacing", t[1] - t[0], W + 1);
      chk("b2b_first_diff", dv[0], 8'h05);
      chk("b2b_first_borrow", bv[0], 1'b0);
      chk("b2b_second_diff", dv[1], SAT ? 8'h00 : 8'hFB);
      chk("b2b_second_borrow", bv[1], 1'b1);
    end
    repeat (12) tick();
    chk("b2b_quiet", {busy, done}, 2'b00);

    // Reset mid-operation (borrow is 1 from the previous result)
    a = 8'd200;
    b = 8'd55;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("midrst_busy_before", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_async_clear", {busy, done, diff, borrow}, '0);
    repeat (2) tick();
    chk("midrst_held", {busy, done, diff, borrow}, '0);
    #2;
    rst_n = 1'b1;
    tick();
    run_op(8'd100, 8'd30, gd, gb, lat, bcnt);
    chk("midrst_after_diff", gd, 8'd70);
    chk("midrst_after_borrow", gb, 1'b0);
    chk("midrst_after_latency", lat, W + 1);

    // Randomised operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 5 == 0) rb = ra + W'($urandom_range(0, 1));
      exp = ref_sub(ra, rb);
      run_op(ra, rb, gd, gb, lat, bcnt);
      chk($sformatf("rnd%0d_diff", i), gd, exp[W-1:0]);
      chk($sformatf("rnd%0d_borrow", i), gb, exp[W]);
      chk($sformatf("rnd%0d_latency", i), lat, W + 1);
      repeat ($urandom_range(0, 3)) tick();
    end

    chk("busy_done_exclusive", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
